mips_mc_controller_hs: RTL and testbench
========================================

// Module: mips_mc_controller_hs
// PURPOSE
//  Parametrised multi-cycle MIPS control FSM with a memory ready/valid handshake,
//  a wait-state timeout, an illegal-opcode trap and a retired-instruction counter.
//  Sits beside the multi-cycle datapath. Drives the datapath mux/enable strobes and a
//  2-bit alu_op into the existing alu_controller. Each memory state stalls until
//  mem_ready instead of assuming single-cycle memory.
// PARAMETERS
//  TO_W    4   width of wait-state counter
//  TO_MAX  15  wait cycles tolerated per memory access before timeout (1..2^TO_W-1)
//  CNT_W   32  width of retired-instruction counter
// PORTS
//  clk            in   1      clock, posedge
//  rst            in   1      synchronous active-high reset
//  opcode         in   6      instr[31:26] from IR
//  zero           in   1      ALU zero flag
//  mem_ready      in   1      memory completed current read/write this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if branch condition true
//  pc_src         out  2      00 alu, 01 jump target, 10 aluout(branch), 11 rs(JR)
//  IorD, ir_write, alu_src_a, mem_read, mem_write, mem_to_reg, reg_write  out 1 each
//  alu_src_b      out  2      00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  reg_dst        out  2      00 rt, 01 rd, 10 $31
//  alu_op         out  2      00 add, 01 sub, 10 func-field, 11 slt
//  pc_load        out  1      pc_write | (pc_write_cond & branch_taken)
//  instr_done     out  1      one-cycle pulse on last state of each instruction
//  illegal        out  1      sticky: undefined opcode decoded
//  timeout        out  1      sticky: memory wait exceeded TO_MAX
//  retired        out  CNT_W  instructions completed since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset: state=FETCH, wait_cnt=0, retired=0, illegal=timeout=0; all strobes 0 during reset cycle.
//  - Outputs are Moore (decoded from state only), except mem-state completion, which gates
//    on mem_ready. pc_load is combinational from state and zero.
//  - FETCH: mem_read=1, alu_src_b=01. Holds until mem_ready. On the mem_ready cycle
//    ir_write=1, pc_write=1, then go to DECODE. ir_write/pc_write=0 while waiting.
//  - DECODE: alu_src_b=11. Next state by opcode:
//    000000 REXE, 000100 BEQ, 000010 JMP, 000011 JAL, 000110 JR, 001001 IEXE(add),
//    001010 IEXE(slt), 100011/101011 MEMADR, anything else TRAP.
//  - MEMADR: alu_src_a=1, alu_src_b=10 -> MEMRD (LW) or MEMWR (SW).
//  - MEMRD: IorD=1, mem_read=1, wait mem_ready -> MEMWB. MEMWB: reg_write=1, mem_to_reg=1, done.
//  - MEMWR: IorD=1, mem_write=1, wait mem_ready, done.
//  - REXE: alu_src_a=1, alu_op=10 -> RWB. RWB: reg_dst=01, reg_write=1, done.
//  - BEQ: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_src=10, done (taken when zero=1).
//  - JMP: pc_write=1, pc_src=01, done.
//  - JAL: reg_dst=10, reg_write=1 -> JMP (done counted in JMP).
//  - JR: pc_write=1, pc_src=11, done.
//  - IEXE: alu_src_a=1, alu_src_b=10, alu_op=00 (ADDI) or 11 (SLTI). Opcode latched in DECODE.
//    -> IWB. IWB: reg_dst=00, reg_write=1, done.
//  - Every "done" state pulses instr_done, increments retired, and returns to FETCH.
//  - Wait counter: cleared on entry to any memory state, increments each cycle mem_ready=0.
//    When it reaches TO_MAX with mem_ready still 0: set timeout, go to HALT.
//    mem_ready on the TO_MAX-th cycle still completes the access normally.
//  - TRAP: set illegal, go to HALT. HALT: all strobes 0, absorbing until rst.
//  - mem_ready outside a memory state is ignored. rst mid-instruction aborts with no strobes
//    the next cycle and restarts at FETCH.
// CONFIGURATION
//  MC_BNE_EN defined: opcode 000101 decodes to BNE. Same strobes as BEQ, but branch taken
//    when zero=0. Branch polarity is latched in DECODE.
//  MC_BNE_EN undefined: 000101 traps as illegal.
// TESTING
//  1. rst high 2 cycles then low, mem_ready=1 -> FETCH asserts mem_read, pc_write, ir_write on
//     cycle 1; retired=0, illegal=timeout=0.
//  2. LW with mem_ready delayed 3 cycles in FETCH and MEMRD -> 5+3+3=11 cycles.
//     instr_done once; retired=1; reg_write&mem_to_reg in MEMWB.
//  3. BEQ with zero=1 -> pc_load=1 in BEQ state; with zero=0 -> pc_load=0; retired +1 each.
//  4. JAL -> reg_dst=10 & reg_write one cycle, then pc_write & pc_src=01; retired +1 only.
//  5. SW with mem_ready held 0 -> timeout=1 after exactly TO_MAX(15) wait cycles;
//     all strobes 0 until rst.
//  6. opcode 111111 -> illegal=1, HALT. opcode 000101 -> BNE (zero=0 takes) iff MC_BNE_EN,
//     else illegal=1.

Source files
------------

// File: rtl/mips_mc_controller_hs.sv
// Multi-cycle MIPS control FSM with memory ready handshake, wait-state timeout,
// illegal-opcode trap and retired counter. Define MC_BNE_EN to decode opcode 000101 as BNE.
module mips_mc_controller_hs #(
    parameter int TO_W   = 4,
    parameter int TO_MAX = 15,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             IorD,
    output logic             ir_write,
    output logic             alu_src_a,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       reg_dst,
    output logic [1:0]       alu_op,
    output logic             pc_load,
    output logic             instr_done,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXE, S_RWB,
        S_BEQ, S_JMP, S_JAL, S_JR, S_IEXE, S_IWB, S_TRAP, S_HALT
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX_C = TO_W'(TO_MAX);

    state_t             r_state_reg;
    state_t             w_state_next;
    logic [TO_W-1:0]    r_wait_cnt_reg;
    logic [CNT_W-1:0]   r_retired_reg;
    logic               r_illegal_reg;
    logic               r_timeout_reg;
    logic               r_is_slt_reg;
    logic               r_is_store_reg;

    logic               w_pc_write;
    logic               w_pc_write_cond;
    logic [1:0]         w_pc_src;
    logic               w_iord;
    logic               w_ir_write;
    logic               w_alu_src_a;
    logic               w_mem_read;
    logic               w_mem_write;
    logic               w_mem_to_reg;
    logic               w_reg_write;
    logic [1:0]         w_alu_src_b;
    logic [1:0]         w_reg_dst;
    logic [1:0]         w_alu_op;
    logic               w_instr_done;
    logic               w_mem_state;
    logic               w_timeout_set;
    logic               w_branch_taken;

`ifdef MC_BNE_EN
    logic               r_bne_reg;
    assign w_branch_taken = r_bne_reg ? ~zero : zero;
`else
    assign w_branch_taken = zero;
`endif

    always_comb begin
        w_state_next    = r_state_reg;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_pc_src        = 2'b00;
        w_iord          = 1'b0;
        w_ir_write      = 1'b0;
        w_alu_src_a     = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_reg_dst       = 2'b00;
        w_alu_op        = 2'b00;
        w_instr_done    = 1'b0;
        w_mem_state     = 1'b0;
        w_timeout_set   = 1'b0;

        case (r_state_reg)
            S_FETCH: begin
                w_mem_state = 1'b1;
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (opcode)
                    6'b000000: w_state_next = S_REXE;
                    6'b000100: w_state_next = S_BEQ;
`ifdef MC_BNE_EN
                    6'b000101: w_state_next = S_BEQ;
`endif
                    6'b000010: w_state_next = S_JMP;
                    6'b000011: w_state_next = S_JAL;
                    6'b000110: w_state_next = S_JR;
                    6'b001001: w_state_next = S_IEXE;
                    6'b001010: w_state_next = S_IEXE;
                    6'b100011: w_state_next = S_MEMADR;
                    6'b101011: w_state_next = S_MEMADR;
                    default:   w_state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_state_next = r_is_store_reg ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_state = 1'b1;
                w_iord      = 1'b1;
                w_mem_read  = 1'b1;
                if (mem_ready) begin
                    w_state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_state = 1'b1;
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_REXE: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b10;
                w_state_next = S_RWB;
            end
            S_RWB: begin
                w_reg_dst    = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_src        = 2'b10;
                w_instr_done    = 1'b1;
                w_state_next    = S_FETCH;
            end
            S_JMP: begin
                w_pc_write   = 1'b1;
                w_pc_src     = 2'b01;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JAL: begin
                w_reg_dst    = 2'b10;
                w_reg_write  = 1'b1;
                w_state_next = S_JMP;
            end
            S_JR: begin
                w_pc_write   = 1'b1;
                w_pc_src     = 2'b11;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_IEXE: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_alu_op     = r_is_slt_reg ? 2'b11 : 2'b00;
                w_state_next = S_IWB;
            end
            S_IWB: begin
                w_reg_dst    = 2'b00;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_TRAP:  w_state_next = S_HALT;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_HALT;
        endcase

        // Counter already at the limit and memory still not ready: give up.
        if (w_mem_state && !mem_ready && (r_wait_cnt_reg == TO_MAX_C)) begin
            w_timeout_set = 1'b1;
            w_state_next  = S_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg    <= S_FETCH;
            r_wait_cnt_reg <= '0;
            r_retired_reg  <= '0;
            r_illegal_reg  <= 1'b0;
            r_timeout_reg  <= 1'b0;
            r_is_slt_reg   <= 1'b0;
            r_is_store_reg <= 1'b0;
`ifdef MC_BNE_EN
            r_bne_reg      <= 1'b0;
`endif
        end else begin
            r_state_reg <= w_state_next;
            // Any state change clears the counter, which covers entry into every memory state.
            if (w_state_next != r_state_reg) begin
                r_wait_cnt_reg <= '0;
            end else if (w_mem_state && !mem_ready) begin
                r_wait_cnt_reg <= r_wait_cnt_reg + TO_W'(1);
            end
            if (w_instr_done) begin
                r_retired_reg <= r_retired_reg + CNT_W'(1);
            end
            if (r_state_reg == S_TRAP) begin
                r_illegal_reg <= 1'b1;
            end
            if (w_timeout_set) begin
                r_timeout_reg <= 1'b1;
            end
            if (r_state_reg == S_DECODE) begin
                r_is_slt_reg   <= (opcode == 6'b001010);
                r_is_store_reg <= (opcode == 6'b101011);
`ifdef MC_BNE_EN
                r_bne_reg      <= (opcode == 6'b000101);
`endif
            end
        end
    end

    // Strobes are forced low during any reset cycle, including a mid-instruction reset.
    assign pc_write      = w_pc_write & ~rst;
    assign pc_write_cond = w_pc_write_cond & ~rst;
    assign pc_src        = rst ? 2'b00 : w_pc_src;
    assign IorD          = w_iord & ~rst;
    assign ir_write      = w_ir_write & ~rst;
    assign alu_src_a     = w_alu_src_a & ~rst;
    assign mem_read      = w_mem_read & ~rst;
    assign mem_write     = w_mem_write & ~rst;
    assign mem_to_reg    = w_mem_to_reg & ~rst;
    assign reg_write     = w_reg_write & ~rst;
    assign alu_src_b     = rst ? 2'b00 : w_alu_src_b;
    assign reg_dst       = rst ? 2'b00 : w_reg_dst;
    assign alu_op        = rst ? 2'b00 : w_alu_op;
    assign pc_load       = (w_pc_write | (w_pc_write_cond & w_branch_taken)) & ~rst;
    assign instr_done    = w_instr_done & ~rst;
    assign illegal       = r_illegal_reg;
    assign timeout       = r_timeout_reg;
    assign retired       = r_retired_reg;

endmodule

// File: tb/tb_mips_mc_controller_hs.sv
// Directed self-checking bench for mips_mc_controller_hs; per-cycle strobe vectors
// are hand-derived for each instruction class.
module tb_mips_mc_controller_hs;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, IorD, ir_write, alu_src_a, mem_read, mem_write;
    logic        mem_to_reg, reg_write, pc_load, instr_done, illegal, timeout;
    logic [1:0]  pc_src, alu_src_b, reg_dst, alu_op;
    logic [31:0] retired;
    logic [18:0] strobes;

    int n_checks = 0;
    int n_errors = 0;

    mips_mc_controller_hs dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .IorD(IorD), .ir_write(ir_write), .alu_src_a(alu_src_a), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_b(alu_src_b), .reg_dst(reg_dst), .alu_op(alu_op), .pc_load(pc_load),
        .instr_done(instr_done), .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    // Field order: pcw pcwc src iord irw asa mr mw m2r rw asb rd aop pcl done
    assign strobes = {pc_write, pc_write_cond, pc_src, IorD, ir_write, alu_src_a, mem_read,
                      mem_write, mem_to_reg, reg_write, alu_src_b, reg_dst, alu_op,
                      pc_load, instr_done};

    localparam logic [18:0] E_ZERO    = 19'b0_0_00_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [18:0] E_FW      = 19'b0_0_00_0_0_0_1_0_0_0_01_00_00_0_0;
    localparam logic [18:0] E_FR      = 19'b1_0_00_0_1_0_1_0_0_0_01_00_00_1_0;
    localparam logic [18:0] E_DEC     = 19'b0_0_00_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [18:0] E_MEMADR  = 19'b0_0_00_0_0_1_0_0_0_0_10_00_00_0_0;
    localparam logic [18:0] E_MEMRD   = 19'b0_0_00_1_0_0_1_0_0_0_00_00_00_0_0;
    localparam logic [18:0] E_MEMWB   = 19'b0_0_00_0_0_0_0_0_1_1_00_00_00_0_1;
    localparam logic [18:0] E_MEMWR_W = 19'b0_0_00_1_0_0_0_1_0_0_00_00_00_0_0;
    localparam logic [18:0] E_MEMWR_R = 19'b0_0_00_1_0_0_0_1_0_0_00_00_00_0_1;
    localparam logic [18:0] E_REXE    = 19'b0_0_00_0_0_1_0_0_0_0_00_00_10_0_0;
    localparam logic [18:0] E_RWB     = 19'b0_0_00_0_0_0_0_0_0_1_00_01_00_0_1;
    localparam logic [18:0] E_BEQ_T   = 19'b0_1_10_0_0_1_0_0_0_0_00_00_01_1_1;
    localparam logic [18:0] E_BEQ_N   = 19'b0_1_10_0_0_1_0_0_0_0_00_00_01_0_1;
    localparam logic [18:0] E_JMP     = 19'b1_0_01_0_0_0_0_0_0_0_00_00_00_1_1;
    localparam logic [18:0] E_JAL     = 19'b0_0_00_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [18:0] E_JR      = 19'b1_0_11_0_0_0_0_0_0_0_00_00_00_1_1;
    localparam logic [18:0] E_IADD    = 19'b0_0_00_0_0_1_0_0_0_0_10_00_00_0_0;
    localparam logic [18:0] E_ISLT    = 19'b0_0_00_0_0_1_0_0_0_0_10_00_11_0_0;
    localparam logic [18:0] E_IWB     = 19'b0_0_00_0_0_0_0_0_0_1_00_00_00_0_1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (strobes !== E_ZERO) begin
                n_errors++; $display("FAIL reset_strobes cyc %0d got %b exp %b", k, strobes, E_ZERO);
            end
        end
        rst = 1'b0; #1;
        n_checks++;
        if (strobes !== E_FR) begin
            n_errors++; $display("FAIL reset_fetch got %b exp %b", strobes, E_FR);
        end
        n_checks++;
        if (retired !== 32'd0 || illegal !== 1'b0 || timeout !== 1'b0) begin
            n_errors++; $display("FAIL reset_state got ret=%0d ill=%b to=%b exp 0 0 0", retired, illegal, timeout);
        end
        $display("reset: fetch strobes %b retired %0d", strobes, retired);
    endtask

    task automatic test_reset_mid();
        logic [18:0] ev [5] = '{E_FR, E_DEC, E_ZERO, E_FW, E_FW};
        logic        rv [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        sv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        opcode = 6'b100011;
        for (int k = 0; k < 5; k++) begin
            mem_ready = rv[k]; rst = sv[k]; #1;
            n_checks++;
            if (strobes !== ev[k]) begin
                n_errors++; $display("FAIL reset_mid cyc %0d got %b exp %b", k, strobes, ev[k]);
            end
            @(posedge clk); #1;
        end
        $display("reset_mid: aborted LW, retired %0d", retired);
    endtask

    task automatic test_lw();
        logic [18:0] ev [12] = '{E_FW, E_FW, E_FW, E_FR, E_DEC, E_MEMADR,
                                 E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB, E_FW};
        logic        rv [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        opcode = 6'b100011;
        for (int k = 0; k < 12; k++) begin
            mem_ready = rv[k]; #1;
            n_checks++;
            if (strobes !== ev[k]) begin
                n_errors++; $display("FAIL lw cyc %0d got %b exp %b", k, strobes, ev[k]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (retired !== 32'd1) begin
            n_errors++; $display("FAIL lw_retired got %0d exp 1", retired);
        end
        $display("lw: 11-cycle load, retired %0d", retired);
    endtask

    task automatic test_beq();
        logic [18:0] ev [7] = '{E_FR, E_DEC, E_BEQ_T, E_FR, E_DEC, E_BEQ_N, E_FW};
        logic        rv [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        zv [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        opcode = 6'b000100;
        for (int k = 0; k < 7; k++) begin
            mem_ready = rv[k]; zero = zv[k]; #1;
            n_checks++;
            if (strobes !== ev[k]) begin
                n_errors++; $display("FAIL beq cyc %0d got %b exp %b", k, strobes, ev[k]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (retired !== 32'd2) begin
            n_errors++; $display("FAIL beq_retired got %0d exp 2", retired);
        end
        $display("beq: taken then not taken, retired %0d", retired);
    endtask

    task automatic test_jal();
        logic [18:0] ev [5] = '{E_FR, E_DEC, E_JAL, E_JMP, E_FW};
        logic        rv [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        opcode = 6'b000011;
        for (int k = 0; k < 5; k++) begin
            mem_ready = rv[k]; #1;
            n_checks++;
            if (strobes !== ev[k]) begin
                n_errors++; $display("FAIL jal cyc %0d got %b exp %b", k, strobes, ev[k]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (retired !== 32'd1) begin
            n_errors++; $display("FAIL jal_retired got %0d exp 1", retired);
        end
        $display("jal: link then jump, retired %0d", retired);
    endtask

    task automatic test_back_to_back();
        // R, ADDI, SLTI (opcode changes in IEXE to prove it was latched), JR, SW
        logic [18:0] ev [20] = '{E_FR, E_DEC, E_REXE, E_RWB,
                                 E_FR, E_DEC, E_IADD, E_IWB,
                                 E_FR, E_DEC, E_ISLT, E_IWB,
                                 E_FR, E_DEC, E_JR,
                                 E_FR, E_DEC, E_MEMADR, E_MEMWR_R, E_FW};
        logic [5:0]  ov [20] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                 6'b001001, 6'b001001, 6'b001001, 6'b001001,
                                 6'b001010, 6'b001010, 6'b001001, 6'b001010,
                                 6'b000110, 6'b000110, 6'b000110,
                                 6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b000000};
        do_reset();
        for (int k = 0; k < 20; k++) begin
            opcode = ov[k]; mem_ready = (k != 19); #1;
            n_checks++;
            if (strobes !== ev[k]) begin
                n_errors++; $display("FAIL b2b cyc %0d got %b exp %b", k, strobes, ev[k]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (retired !== 32'd5) begin
            n_errors++; $display("FAIL b2b_retired got %0d exp 5", retired);
        end
        $display("back_to_back: R ADDI SLTI JR SW, retired %0d", retired);
    endtask

    task automatic test_timeout();
        logic [18:0] ev [3] = '{E_FR, E_DEC, E_MEMADR};
        do_reset();
        opcode = 6'b101011;
        for (int k = 0; k < 3; k++) begin
            mem_ready = (k == 0); #1;
            n_checks++;
            if (strobes !== ev[k]) begin
                n_errors++; $display("FAIL to_pre cyc %0d got %b exp %b", k, strobes, ev[k]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_checks++;
            if (strobes !== E_MEMWR_W || timeout !== 1'b0) begin
                n_errors++; $display("FAIL to_wait cyc %0d got %b to=%b exp %b to=0", k, strobes, timeout, E_MEMWR_W);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (strobes !== E_ZERO || timeout !== 1'b1) begin
                n_errors++; $display("FAIL to_halt cyc %0d got %b to=%b exp %b to=1", k, strobes, timeout, E_ZERO);
            end
            @(posedge clk); #1;
        end
        $display("timeout: SW stalled, timeout %b retired %0d", timeout, retired);
    endtask

    task automatic test_to_boundary();
        do_reset();
        opcode = 6'b100011;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b1; #1;
        n_checks++;
        if (strobes !== E_MEMRD || timeout !== 1'b0) begin
            n_errors++; $display("FAIL to_bound_rd got %b to=%b exp %b to=0", strobes, timeout, E_MEMRD);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0; #1;
        n_checks++;
        if (strobes !== E_MEMWB || timeout !== 1'b0) begin
            n_errors++; $display("FAIL to_bound_wb got %b to=%b exp %b to=0", strobes, timeout, E_MEMWB);
        end
        $display("to_boundary: ready after 15 waits, timeout %b", timeout);
    endtask

    task automatic test_illegal();
        logic [18:0] ev [5] = '{E_FR, E_DEC, E_ZERO, E_ZERO, E_ZERO};
        do_reset();
        opcode = 6'b111111;
        for (int k = 0; k < 5; k++) begin
            mem_ready = 1'b1 ^ (k == 1); #1;
            n_checks++;
            if (strobes !== ev[k]) begin
                n_errors++; $display("FAIL illegal cyc %0d got %b exp %b", k, strobes, ev[k]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (illegal !== 1'b1 || timeout !== 1'b0 || retired !== 32'd0) begin
            n_errors++; $display("FAIL illegal_flag got ill=%b to=%b ret=%0d exp 1 0 0", illegal, timeout, retired);
        end
        $display("illegal: opcode 111111, illegal %b", illegal);
    endtask

    task automatic test_bne();
`ifdef MC_BNE_EN
        logic [18:0] ev [7] = '{E_FR, E_DEC, E_BEQ_T, E_FR, E_DEC, E_BEQ_N, E_FW};
        logic        zv [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_ret = 32'd2;
        logic        exp_ill = 1'b0;
`else
        logic [18:0] ev [7] = '{E_FR, E_DEC, E_ZERO, E_ZERO, E_ZERO, E_ZERO, E_ZERO};
        logic        zv [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_ret = 32'd0;
        logic        exp_ill = 1'b1;
`endif
        do_reset();
        opcode = 6'b000101;
        for (int k = 0; k < 7; k++) begin
            mem_ready = (k == 0 || k == 3); zero = zv[k]; #1;
            n_checks++;
            if (strobes !== ev[k]) begin
                n_errors++; $display("FAIL bne cyc %0d got %b exp %b", k, strobes, ev[k]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (retired !== exp_ret || illegal !== exp_ill) begin
            n_errors++; $display("FAIL bne_flags got ret=%0d ill=%b exp ret=%0d ill=%b", retired, illegal, exp_ret, exp_ill);
        end
        $display("bne: opcode 000101, retired %0d illegal %b", retired, illegal);
    endtask

    initial begin
        rst = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_reset_mid();
        test_lw();
        test_beq();
        test_jal();
        test_back_to_back();
        test_timeout();
        test_to_boundary();
        test_illegal();
        test_bne();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
